imm_encoder: RTL and testbench

- Inverse of the core's immediate-extension unit: packs a 32-bit signed immediate into the immediate bit-fields of a RISC-V instruction word.
- The immediate format is selected by the same 2-bit ImmSrc code the core uses. Fields come from a caller-supplied instruction template.
- Two-stage valid/ready pipeline with range/alignment checking and handshake counters.
- Sits between the program loader/self-test generator and instruction memory write port.

---
 rtl/imm_encoder.sv | 124 ++++++++++++
 tb/tb_imm_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Packs a signed immediate into the I/S/B/J fields of an instruction
// template; two-stage valid/ready pipeline with range checks and counters.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_tmpl,
  input  logic [31:0]      in_imm,
  input  logic [1:0]       in_immsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  logic        s1_valid;
  logic [31:0] s1_tmpl;
  logic [31:0] s1_imm;
  immsrc_e     s1_src;

  logic        s2_load;
  logic        accept;
  logic        out_fire;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic        ok12;
  logic        ok13;
  logic        ok21;

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // sign-extension checks: upper bits must all match the field's top bit
  assign ok12 = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
  assign ok13 = (&s1_imm[31:12]) | ~(|s1_imm[31:12]);
  assign ok21 = (&s1_imm[31:20]) | ~(|s1_imm[31:20]);

  always_comb begin
    enc_inst = s1_tmpl;
    enc_err  = 1'b0;
    unique case (s1_src)
      IMM_I: begin
        enc_inst[31:20] = s1_imm[11:0];
        enc_err         = ~ok12;
      end
      IMM_S: begin
        enc_inst[31:25] = s1_imm[11:5];
        enc_inst[11:7]  = s1_imm[4:0];
        enc_err         = ~ok12;
      end
      IMM_B: begin
        enc_inst[31]    = s1_imm[12];
        enc_inst[7]     = s1_imm[11];
        enc_inst[30:25] = s1_imm[10:5];
        enc_inst[11:8]  = s1_imm[4:1];
        enc_err         = ~ok13 | s1_imm[0];
      end
      IMM_J: begin
        enc_inst[31]    = s1_imm[20];
        enc_inst[19:12] = s1_imm[19:12];
        enc_inst[20]    = s1_imm[11];
        enc_inst[30:21] = s1_imm[10:1];
        enc_err         = ~ok21 | s1_imm[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tmpl  <= '0;
      s1_imm   <= '0;
      s1_src   <= IMM_I;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_tmpl  <= in_tmpl;
      s1_imm   <= in_imm;
      s1_src   <= immsrc_e'(in_immsrc);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_inst  <= enc_inst;
      out_err   <= enc_err;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_fire) begin
      enc_count <= enc_count + 1'b1;
      if (out_err)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and scoreboarded checks for imm_encoder: encodings, range
// errors, backpressure, random streaming and mid-flight reset.
module tb_imm_encoder;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_tmpl;
  logic [31:0]      in_imm;
  logic [1:0]       in_immsrc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int vectors = 0;
  int miscompares = 0;
  bit rnd = 0;
  int exp_enc = 0;
  int exp_err = 0;
  logic [32:0] q[$];

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_tmpl(in_tmpl),
    .in_imm(in_imm),
    .in_immsrc(in_immsrc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_err(out_err),
    .enc_count(enc_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: range test in signed arithmetic, fields packed per table
  function automatic logic [32:0] ref_enc(input logic [31:0] t,
                                          input logic [31:0] i,
                                          input logic [1:0] s);
    int v;
    logic e;
    logic [31:0] w;
    v = $signed(i);
    w = t;
    e = 1'b0;
    case (s)
      2'd0: begin
        e = (v < -2048) || (v > 2047);
        w[31:20] = i[11:0];
      end
      2'd1: begin
        e = (v < -2048) || (v > 2047);
        w[31:25] = i[11:5];
        w[11:7]  = i[4:0];
      end
      2'd2: begin
        e = (v < -4096) || (v > 4095) || i[0];
        w[31]    = i[12];
        w[7]     = i[11];
        w[30:25] = i[10:5];
        w[11:8]  = i[4:1];
      end
      default: begin
        e = (v < -1048576) || (v > 1048575) || i[0];
        w[31]    = i[20];
        w[19:12] = i[19:12];
        w[20]    = i[11];
        w[30:21] = i[10:1];
      end
    endcase
    return {e, w};
  endfunction

  // scoreboard: handshakes sampled at negedge, where inputs are settled
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_enc = 0;
      exp_err = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {31'b0, out_err, out_inst}, 64'h0);
        end else begin
          chk("stream_word", {31'b0, out_err, out_inst},
              {31'b0, q[0]});
          exp_err += int'(q[0][32]);
          void'(q.pop_front());
        end
        exp_enc++;
      end
      if (in_valid && in_ready)
        q.push_back(ref_enc(in_tmpl, in_imm, in_immsrc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [31:0] t,
                      input logic [31:0] i,
                      input logic [1:0] s);
    logic acc;
    int n;
    in_tmpl = t;
    in_imm = i;
    in_immsrc = s;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    logic [31:0] im;
    logic [1:0] s;
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    in_tmpl = '0;
    in_imm = '0;
    in_immsrc = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_enc_count", 64'(enc_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // I-type latency and encoding
    send(32'h0000_0013, 32'hFFFF_FFFF, 2'd0);
    chk("i_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("i_valid", 64'(out_valid), 64'd1);
    chk("i_inst", 64'(out_inst), 64'hFFF0_0013);
    chk("i_err", 64'(out_err), 64'd0);
    tick();
    chk("i_enc_count", 64'(enc_count), 64'd1);

    // B-type then J-type
    send(32'h0000_0063, 32'hFFFF_FFFC, 2'd2);
    tick();
    chk("b_inst", 64'(out_inst), 64'hFE00_0EE3);
    chk("b_err", 64'(out_err), 64'd0);
    send(32'h0000_006F, 32'h0000_0008, 2'd3);
    tick();
    chk("j_inst", 64'(out_inst), 64'h0080_006F);
    chk("j_err", 64'(out_err), 64'd0);
    tick();

    // error cases: truncated bits are still packed
    do_reset();
    send(32'h0000_0023, 32'h0000_0800, 2'd1);
    tick();
    chk("s_err", 64'(out_err), 64'd1);
    chk("s_hi", 64'(out_inst[31:25]), 64'h40);
    chk("s_lo", 64'(out_inst[11:7]), 64'h0);
    send(32'h0000_0063, 32'h0000_0003, 2'd2);
    tick();
    chk("b_odd_err", 64'(out_err), 64'd1);
    chk("b_odd_inst", 64'(out_inst), 64'h0000_0163);
    tick();
    chk("e_enc_count", 64'(enc_count), 64'd2);
    chk("e_err_count", 64'(err_count), 64'd2);

    // backpressure: two in flight, third held off
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_tmpl = 32'h0000_0013;
    in_imm = 32'd5;
    in_immsrc = 2'd0;
    tick();
    in_tmpl = 32'h0000_006F;
    in_imm = 32'd8;
    in_immsrc = 2'd3;
    tick();
    in_tmpl = 32'h0000_0023;
    in_imm = 32'hFFFF_FFFC;
    in_immsrc = 2'd1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'(out_inst), 64'h0050_0013);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_second", 64'(out_inst), 64'h0080_006F);
    tick();
    chk("bp_third", 64'(out_inst), 64'hFE00_0E23);
    tick();
    chk("bp_enc_count", 64'(enc_count), 64'd3);

    // random streaming against the scoreboard
    do_reset();
    rnd = 1;
    for (int k = 0; k < 100; k++) begin
      t = $urandom;
      s = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: im = $urandom_range(0, 4095) - 2048;
        1: im = ($urandom_range(0, 8191) - 4096) & ~32'd1;
        2: im = $urandom_range(0, 2097151) - 1048576;
        default: im = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) tick();
      send(t, im, s);
    end
    rnd = 0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    chk("st_enc_count", 64'(enc_count), 64'(exp_enc));
    chk("st_err_count", 64'(err_count), 64'(exp_err));

    // reset with two requests in flight
    out_ready = 1'b0;
    send(32'h0000_0013, 32'd1, 2'd0);
    send(32'h0000_0013, 32'd2, 2'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_enc_count", 64'(enc_count), 64'd0);
    chk("mr_err_count", 64'(err_count), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_no_stale", 64'(out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
